// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read/1-write register file.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// Combinational read port: register select, hardwired zero and optional
// write-through forwarding (enabled by defining REGFILE_BYPASS_EN).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                             i_resetn,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  i_regs,
  input  logic [ADDR_W-1:0]                i_rn,
  input  logic                             i_write,
  input  logic [ADDR_W-1:0]                i_wn,
  input  logic [DATA_W-1:0]                i_wd,
  output logic [DATA_W-1:0]                o_data
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

`ifdef REGFILE_BYPASS_EN
  logic w_fwd;
  assign w_fwd = i_write && (i_wn != ZeroAddr) && (i_wn == i_rn);
`else
  logic w_unused;
  assign w_unused = ^{i_write, i_wn, i_wd};
`endif

  always_comb begin
    o_data = '0;
    if (!i_resetn || (i_rn == ZeroAddr)) begin
      o_data = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (w_fwd) begin
      o_data = i_wd;
`endif
    end else begin
      o_data = i_regs[i_rn];
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// 32-entry register file, two async read ports and one sync write port.
// Optional write-through forwarding via the REGFILE_BYPASS_EN macro.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
  parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  input  logic [ADDR_W-1:0] i_rn1,
  input  logic [ADDR_W-1:0] i_rn2,
  input  logic [ADDR_W-1:0] i_wn,
  input  logic              i_write,
  input  logic [DATA_W-1:0] i_wd,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_regs <= '0;
    end else if (i_write && (i_wn != ZeroAddr)) begin
      r_regs[i_wn] <= i_wd;
    end
  end

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_port_a (
    .i_resetn (i_resetn),
    .i_regs   (r_regs),
    .i_rn     (i_rn1),
    .i_write  (i_write),
    .i_wn     (i_wn),
    .i_wd     (i_wd),
    .o_data   (o_a)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_port_b (
    .i_resetn (i_resetn),
    .i_regs   (r_regs),
    .i_rn     (i_rn2),
    .i_write  (i_write),
    .i_wn     (i_wn),
    .i_wd     (i_wd),
    .o_data   (o_b)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed plan plus random traffic
// against an array model. Honours REGFILE_BYPASS_EN when defined.
module tb_regfile_2r1w;
  import regfile_pkg::*;

  logic      clk;
  logic      resetn;
  reg_addr_t rn1, rn2, wn;
  logic      write;
  reg_data_t wd;
  reg_data_t a, b;

  int n_cmp = 0;
  int n_bad = 0;

  reg_data_t model [NUM_REGS];

  regfile_2r1w u_dut (
    .i_clock  (clk),
    .i_resetn (resetn),
    .i_rn1    (rn1),
    .i_rn2    (rn2),
    .i_wn     (wn),
    .i_write  (write),
    .i_wd     (wd),
    .o_a      (a),
    .o_b      (b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input reg_data_t got, input reg_data_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected read value from the architectural register state and the
  // write request currently presented.
  function automatic reg_data_t exp_read(input reg_addr_t rn);
    if (!resetn || rn == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (write && wn != 0 && wn == rn) return wd;
`endif
    return model[rn];
  endfunction

  initial begin
    resetn = 1'b0;
    rn1 = '0; rn2 = '0; wn = '0; write = 1'b0; wd = '0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    // Reset held for a cycle; a write attempted meanwhile must be dropped.
    write = 1'b1; wn = 5'd2; wd = 32'h0000_0055;
    step();
    write = 1'b0;
    resetn = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      rn1 = reg_addr_t'(i);
      rn2 = reg_addr_t'(NUM_REGS - 1 - i);
      #1;
      check_eq($sformatf("rst_a[%0d]", i), a, 32'd0);
      check_eq($sformatf("rst_b[%0d]", NUM_REGS - 1 - i), b, 32'd0);
    end

    // Basic write / read.
    wn = 5'd1; wd = 32'd1023; write = 1'b1;
    step();
    write = 1'b0; rn1 = 5'd1; rn2 = 5'd3;
    #1;
    check_eq("wr1_a", a, 32'd1023);
    check_eq("wr1_b", b, 32'd0);
    rn2 = 5'd2;
    #1;
    check_eq("rst_blocked_wr", b, 32'd0);

    wn = 5'd3; wd = 32'd2047; write = 1'b1;
    step();
    write = 1'b0; rn1 = 5'd1; rn2 = 5'd3;
    #1;
    check_eq("wr3_a", a, 32'd1023);
    check_eq("wr3_b", b, 32'd2047);

    // Disabled write and attempted write to reg 0.
    write = 1'b0; wn = 5'd1; wd = 32'hDEAD_BEEF;
    step();
    check_eq("wr_dis", a, 32'd1023);
    write = 1'b1; wn = 5'd0; wd = 32'hFFFF_FFFF;
    step();
    write = 1'b0; rn1 = 5'd0;
    #1;
    check_eq("reg0_a", a, 32'd0);

    // Asynchronous reset pulse between clock edges.
    rn1 = 5'd1; rn2 = 5'd3;
    #1;
    check_eq("pre_rst_a", a, 32'd1023);
    check_eq("pre_rst_b", b, 32'd2047);
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_a", a, 32'd0);
    check_eq("mid_rst_b", b, 32'd0);
    #1;
    resetn = 1'b1;
    #1;
    check_eq("post_rst_a", a, 32'd0);
    check_eq("post_rst_b", b, 32'd0);

    // Same-cycle write and read of one address.
    step();
    write = 1'b1; wn = 5'd5; wd = 32'd77; rn1 = 5'd5; rn2 = 5'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_eq("coll_pre", a, 32'd77);
`else
    check_eq("coll_pre", a, 32'd0);
`endif
    step();
    check_eq("coll_post", a, 32'd77);
    write = 1'b0; rn2 = 5'd5;
    #1;
    check_eq("same_addr_a", a, 32'd77);
    check_eq("same_addr_b", b, 32'd77);
    model[5] = 32'd77;

    // Random traffic against the array model.
    for (int n = 0; n < 300; n++) begin
      rn1   = reg_addr_t'($urandom_range(NUM_REGS - 1));
      rn2   = ($urandom_range(3) == 0) ? rn1 : reg_addr_t'($urandom_range(NUM_REGS - 1));
      wn    = ($urandom_range(3) == 0) ? rn1 : reg_addr_t'($urandom_range(NUM_REGS - 1));
      write = $urandom_range(1) == 1;
      wd    = $urandom;
      #1;
      check_eq($sformatf("rnd_pre_a[%0d]", n), a, exp_read(rn1));
      check_eq($sformatf("rnd_pre_b[%0d]", n), b, exp_read(rn2));
      @(posedge clk);
      if (write && wn != 0) model[wn] = wd;
      #1;
      check_eq($sformatf("rnd_post_a[%0d]", n), a, exp_read(rn1));
      check_eq($sformatf("rnd_post_b[%0d]", n), b, exp_read(rn2));
    end

    // Final readback of every register with writes idle.
    write = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rn1 = reg_addr_t'(i);
      rn2 = reg_addr_t'(i);
      #1;
      check_eq($sformatf("final_a[%0d]", i), a, model[i]);
      check_eq($sformatf("final_b[%0d]", i), b, model[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
